// File: rtl/bsh_pkg.sv
// bsh_pkg: shared widths, op encodings and FSM states for the sequential barrel shifter.
package bsh_pkg;
  localparam int DW = 32;
  localparam int SW = 5;
  typedef enum logic [2:0] {
    OP_ROL = 3'b000,
    OP_ROR = 3'b001,
    OP_SLL = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100
  } op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/bsh_seq_32_if.sv
// bsh_seq_32_if: request/result handshake bundle for bsh_seq_32.
interface bsh_seq_32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [2:0]  op;
  logic [4:0]  sh;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  modport master (output in_valid, data_in, op, sh, out_ready, input in_ready, out_valid, data_out);
  modport slave (input in_valid, data_in, op, sh, out_ready, output in_ready, out_valid, data_out);
endinterface

// File: rtl/bsh_stage.sv
// bsh_stage: combinational mover for one log-shifter stage (distance 2^k) in the op's direction.
module bsh_stage
  import bsh_pkg::*;
(
  input  logic [DW-1:0] word_i,
  input  logic [2:0]    k_i,
  input  logic          en_i,
  input  logic [2:0]    op_i,
  input  logic          fill_i,
  output logic [DW-1:0] word_o
);
  logic [5:0]    amt, inv;
  logic [DW-1:0] srl, mv;
  assign amt = 6'd1 << k_i;
  assign inv = 6'd32 - amt;
  assign srl = word_i >> amt;
  // Rotate right is done natively so ROR never depends on a 32-sh rewrite.
  assign mv = op_i == OP_ROR ? srl | (word_i << inv)
            : op_i == OP_SLL ? word_i << amt
            : op_i == OP_SRL ? srl
            : op_i == OP_SRA ? srl | ({DW{fill_i}} & ~({DW{1'b1}} >> amt))
            : (word_i << amt) | (word_i >> inv);
  assign word_o = en_i ? mv : word_i;
endmodule

// File: rtl/bsh_seq_32.sv
// bsh_seq_32: 32-bit sequential shifter/rotator, one log stage per cycle, fixed 5-cycle latency.
// BSH_SEQ_ARITH_EN enables sign-filling SRA for op=100; otherwise op=100 is SRL.
module bsh_seq_32
  import bsh_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  bsh_seq_32_if.slave  bus
);
  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d, op_q, op_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [DW-1:0] work_q, work_d, stage_out;
  logic          fill;
`ifdef BSH_SEQ_ARITH_EN
  logic          sign_q, sign_d;
  assign fill = sign_q;
`else
  assign fill = 1'b0;
`endif
  bsh_stage u_stage (
    .word_i (work_q),
    .k_i    (cnt_q),
    .en_i   (|(sh_q & (5'd1 << cnt_q))),
    .op_i   (op_q),
    .fill_i (fill),
    .word_o (stage_out)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    op_d    = op_q;
    sh_d    = sh_q;
`ifdef BSH_SEQ_ARITH_EN
    sign_d  = sign_q;
`endif
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = BUSY;
        cnt_d   = '0;
        work_d  = bus.data_in;
        sh_d    = bus.sh;
`ifdef BSH_SEQ_ARITH_EN
        op_d    = bus.op;
        sign_d  = bus.data_in[DW-1];
`else
        op_d    = bus.op == OP_SRA ? OP_SRL : bus.op;
`endif
      end
      BUSY: begin
        work_d  = stage_out;
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == 3'd4 ? DONE : BUSY;
      end
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      op_q    <= '0;
      sh_q    <= '0;
`ifdef BSH_SEQ_ARITH_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
`ifdef BSH_SEQ_ARITH_EN
      sign_q  <= sign_d;
`endif
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.data_out  = work_q;
endmodule

// File: tb/tb_bsh_seq_32.sv
// tb_bsh_seq_32: directed vectors, corner sequences and random ops against a reference model.
module tb_bsh_seq_32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  bsh_seq_32_if bus ();
  bsh_seq_32 u_dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] d;
    logic [2:0]  op;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];
  function automatic logic [31:0] model(logic [31:0] d, logic [2:0] o, logic [4:0] s);
    logic [63:0] t;
    case (o)
      3'd1: begin t = {d, d} >> s; return t[31:0]; end
      3'd2: return d << s;
      3'd3: return d >> s;
`ifdef BSH_SEQ_ARITH_EN
      3'd4: return $signed(d) >>> s;
`else
      3'd4: return d >> s;
`endif
      default: begin t = {d, d} << s; return t[63:32]; end
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  task automatic do_op(input logic [31:0] d, input logic [2:0] o, input logic [4:0] s,
                       output logic [31:0] res, output int lat);
    int n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.op       = o;
    bus.sh       = s;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.data_in  = $urandom;
    bus.op       = 3'($urandom);
    bus.sh       = 5'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = bus.data_out;
  endtask
  initial begin
    logic [31:0] res, d;
    logic [2:0]  o;
    logic [4:0]  s;
    int          lat;
    vecs[0] = '{32'h8000_0001, 3'd0, 5'd1,  32'h0000_0003};
    vecs[1] = '{32'h0000_0001, 3'd1, 5'd31, 32'h0000_0002};
    vecs[2] = '{32'h0000_0001, 3'd1, 5'd0,  32'h0000_0001};
`ifdef BSH_SEQ_ARITH_EN
    vecs[3] = '{32'h8000_0000, 3'd4, 5'd4,  32'hF800_0000};
`else
    vecs[3] = '{32'h8000_0000, 3'd4, 5'd4,  32'h0800_0000};
`endif
    vecs[4] = '{32'h0000_FFFF, 3'd2, 5'd16, 32'hFFFF_0000};
    vecs[5] = '{32'hF000_0000, 3'd3, 5'd28, 32'h0000_000F};
    vecs[6] = '{32'h1234_5678, 3'd7, 5'd4,  32'h2345_6781};
    vecs[7] = '{32'h1234_5678, 3'd1, 5'd8,  32'h7812_3456};
    vecs[8] = '{32'h8000_0000, 3'd3, 5'd31, 32'h0000_0001};
    vecs[9] = '{32'hDEAD_BEEF, 3'd5, 5'd0,  32'hDEAD_BEEF};
    bus.in_valid = 1'b0; bus.data_in = '0; bus.op = '0; bus.sh = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset data_out", bus.data_out, 32'd0);
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].d, vecs[i].op, vecs[i].sh, res, lat);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd5);
    end
    // backpressure: result and handshake frozen while consumer stalls
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    do_op(32'h0000_FFFF, 3'd2, 5'd16, res, lat);
    check("bp latency", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold data", bus.data_out, 32'hFFFF_0000);
      check("bp hold flags", {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp leave cycle", {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
    @(posedge clk); #1;
    check("bp idle after", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    // reset during stage 2 aborts the operation
    bus.in_valid = 1'b1; bus.data_in = 32'h1234_5678; bus.op = 3'd3; bus.sh = 5'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midbusy rst flags", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    check("midbusy rst data", bus.data_out, 32'd0);
    repeat (6) @(posedge clk);
    #1 check("midbusy no result", {31'd0, bus.out_valid}, 32'd0);
    do_op(32'hF000_0000, 3'd3, 5'd28, res, lat);
    check("post rst srl", res, 32'h0000_000F);
    // reset beats a simultaneous request
    @(posedge clk); #1;
    rst = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    check("rst priority", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      o = 3'($urandom);
      s = 5'($urandom);
      do_op(d, o, s, res, lat);
      check($sformatf("rand op%0d sh%0d d=%h", o, s, d), res, model(d, o, s));
      if (lat != 5) check("rand latency", 32'(lat), 32'd5);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bsh_seq_32.md
BSH_SEQ_32 -- requirements
Module: bsh_seq_32

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 data_in  input  32  operand.
REQ-007 op  input  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA; 101-111 treated as ROL.
REQ-008 sh  input  5  shift/rotate amount, 0-31.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 data_out  output  32  result, registered.

Function
REQ-012 States SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 IDLE: when in_valid=1, capture data_in, op and sh; clear stage counter to 0; go to BUSY.
REQ-014 BUSY: each cycle processes stage k (k = counter 0..4); if sh[k]=1, move the working register by 2^k bits in the op's direction, else hold it; counter increments.
REQ-015 After stage 4 completes, the block SHALL go to DONE.
REQ-016 Latency SHALL be fixed at 5 BUSY cycles for every sh, including sh=0.
  - Accept edge E0; out_valid rises after edge E5.
REQ-017 Fill rules:
  - ROL/ROR: bits wrap around.
  - SLL/SRL: vacated bits are 0.
  - SRA: vacated bits are copies of captured data_in[31].
REQ-018 ROR SHALL rotate right directly per stage; no conversion to a left rotate by (32-sh).
REQ-019 DONE: data_out and out_valid SHALL hold stable while out_ready=0; when out_ready=1, go to IDLE.
REQ-020 The block SHALL accept no new request in the cycle it leaves DONE; in_ready rises the following cycle.
REQ-021 Input changes while in BUSY or DONE SHALL be ignored.
REQ-022 sh=0 SHALL return data_in unchanged for every op.

Reset
REQ-023 With rst=1 at a rising edge, the block SHALL enter IDLE in that cycle.
  - Outputs after reset: in_ready=1, out_valid=0, data_out=0, counter=0.
REQ-024 Reset mid-BUSY or in DONE SHALL abort the operation with no result emitted.
REQ-025 rst SHALL take priority over in_valid in the same cycle.

Configuration
REQ-026 Macro BSH_SEQ_ARITH_EN SHALL control arithmetic right shift.
  - Defined: op=100 performs SRA.
  - Undefined: op=100 behaves as SRL and no sign-fill logic is synthesised.

Structure
REQ-027 A shared package bsh_pkg SHALL hold the op encodings and the state enumeration, plus constants DW=32 and SW=5.
REQ-028 One sub-module bsh_stage SHALL exist: combinational single-stage mover.
  - Inputs: word, stage index, enable, op, fill bit.
  - Instantiated once and reused each BUSY cycle.

Verification
REQ-029 ROL: data_in=0x80000001, sh=1 -> data_out=0x00000003; out_valid high exactly 5 cycles after accept.
REQ-030 ROR: data_in=0x00000001, sh=31 -> 0x00000002.
  - ROR, sh=0 -> 0x00000001.
REQ-031 SRA: data_in=0x80000000, sh=4 -> 0xF8000000 with BSH_SEQ_ARITH_EN defined; 0x08000000 without it.
REQ-032 Backpressure: SLL, data_in=0x0000FFFF, sh=16, out_ready held 0 for 10 cycles -> data_out stays 0xFFFF0000 and in_ready stays 0.
  - Release out_ready -> IDLE, then in_ready=1 one cycle later.
REQ-033 Reset mid-BUSY: rst pulsed at stage 2 -> next cycle in_ready=1, out_valid=0, data_out=0.
  - A new SRL request (data_in=0xF0000000, sh=28) then yields 0x0000000F.
